// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM burst controller.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDRAIN,
    ST_DONE
  } state_e;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_e;

endpackage

// File: rtl/ram.sv
// 256x64 single-port RAM: synchronous write, combinational read gated by cen.
module ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              cen,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (cen && wen) mem[addr] <= din;
  end

  assign dout = (cen && !wen) ? mem[addr] : '0;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller: one command, then streamed write beats or read words
// over valid/ready, sole master of the single-port RAM.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    ram_cen    = 1'b0;
    ram_wen    = 1'b0;
    ram_din    = '0;

    // A handshake empties the output register; a read issued in the same
    // cycle refills it below.
    if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          cnt_d      = cmd_len;
          state_d    = (dir_e'(cmd_write) == DIR_WRITE) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_cen    = 1'b1;
          ram_wen    = 1'b1;
          ram_din    = wr_data;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          cnt_d      = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = ST_DONE;
        end
      end
      ST_READ: begin
        if (!rd_valid_q || rd_ready) begin
          ram_cen    = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = ram_dout;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          cnt_d      = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = ST_RDRAIN;
        end
      end
      ST_RDRAIN: begin
        if (rd_valid_q && rd_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ram_addr = cur_addr_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with the RAM model behind it.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, cmd_len;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [63:0] rd_data;
  logic        busy, done;
  logic        ram_cen, ram_wen;
  logic [7:0]  ram_addr;
  logic [63:0] ram_din, ram_dout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [63:0] d0, d1, d2, d3;
    logic [3:0]  pat;
    int          lat;
    bit          pulse;
  } vec_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [63:0] d;
  } wexp_t;

  vec_t        tbl [10];
  logic [63:0] exp_mem [256];
  logic [63:0] rd_q [$];
  wexp_t       wr_q [$];

  ram_burst_ctrl #(.ADDR_W(8), .DATA_W(64), .LEN_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  ram #(.ADDR_W(8), .DATA_W(64)) u_ram (
    .clk(clk), .cen(ram_cen), .wen(ram_wen), .addr(ram_addr),
    .din(ram_din), .dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dsel(input vec_t v, input int i);
    case (i)
      0:       return v.d0;
      1:       return v.d1;
      2:       return v.d2;
      default: return v.d3;
    endcase
  endfunction

  task automatic run_burst(input vec_t v);
    int          n0;
    int          beat;
    bit          fin;
    bit          stalled;
    logic [63:0] held;
    logic [7:0]  a;
    wexp_t       we;
    logic [63:0] re;

    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.addr + i[7:0];
      if (v.wr) begin
        wr_q.push_back('{a: a, d: dsel(v, i)});
        exp_mem[a] = dsel(v, i);
      end else begin
        rd_q.push_back(exp_mem[a]);
      end
    end

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    n0 = cyc;
    beat = 0; fin = 1'b0; stalled = 1'b0; held = '0;

    for (int k = 0; k < 64 && !fin; k++) begin
      @(posedge clk); #1;
      cmd_valid = v.pulse && (k == 1);
      cmd_write = !v.wr;
      cmd_addr  = 8'hee;
      cmd_len   = 8'h05;
      if (v.wr) begin
        wr_valid = (beat <= int'(v.len));
        wr_data  = dsel(v, beat);
      end else begin
        rd_ready = v.pat[k % 4];
      end
      @(negedge clk);
      if (cmd_valid) chk("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
      if (stalled) chk("rd_hold", rd_data, held);
      if (v.wr && wr_valid && wr_ready) begin
        if (wr_q.size() == 0) begin
          chk("wr_extra_beat", 64'd1, 64'd0);
        end else begin
          we = wr_q.pop_front();
          chk("wr_cen_wen", {62'd0, ram_cen, ram_wen}, 64'd3);
          chk("wr_addr", {56'd0, ram_addr}, {56'd0, we.a});
          chk("wr_din", ram_din, we.d);
        end
        beat++;
      end
      if (!v.wr && rd_valid && rd_ready) begin
        if (rd_q.size() == 0) begin
          chk("rd_extra_word", 64'd1, 64'd0);
        end else begin
          re = rd_q.pop_front();
          chk("rd_data", rd_data, re);
        end
      end
      if (rd_valid && !rd_ready) begin
        chk("stall_cen", {63'd0, ram_cen}, 64'd0);
        held = rd_data;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        fin = 1'b1;
        if (v.lat >= 0) chk("done_latency", 64'(cyc - n0), 64'(v.lat));
      end
    end
    if (!fin) chk("done_timeout", 64'd0, 64'd1);
    chk("words_left", 64'(wr_q.size() + rd_q.size()), 64'd0);
    wr_q.delete();
    rd_q.delete();

    @(posedge clk); #1;
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    //         wr    addr    len    d0              d1      d2      d3      pat      lat pulse
    tbl[0] = '{1'b1, 8'd10,  8'd2, 64'h12aabbcc,   64'h34, 64'h56, 64'h0,  4'b1111, 4,  1'b0};
    tbl[1] = '{1'b0, 8'd10,  8'd2, 64'h0,          64'h0,  64'h0,  64'h0,  4'b1111, 5,  1'b0};
    tbl[2] = '{1'b0, 8'd10,  8'd2, 64'h0,          64'h0,  64'h0,  64'h0,  4'b1001, -1, 1'b0};
    tbl[3] = '{1'b1, 8'd255, 8'd1, 64'haaaa_0001,  64'hbbbb_0002, 64'h0, 64'h0, 4'b1111, 3, 1'b0};
    tbl[4] = '{1'b0, 8'd255, 8'd1, 64'h0,          64'h0,  64'h0,  64'h0,  4'b1111, 4,  1'b0};
    tbl[5] = '{1'b0, 8'd0,   8'd0, 64'h0,          64'h0,  64'h0,  64'h0,  4'b1111, 3,  1'b0};
    tbl[6] = '{1'b1, 8'd20,  8'd3, 64'hdead_beef_0000_0001, 64'hffff_ffff_ffff_ffff,
                                   64'h8000_0000_0000_0000, 64'h0123_4567_89ab_cdef, 4'b1111, 5, 1'b1};
    tbl[7] = '{1'b0, 8'd20,  8'd3, 64'h0,          64'h0,  64'h0,  64'h0,  4'b0110, -1, 1'b1};
    tbl[8] = '{1'b1, 8'd100, 8'd3, 64'h0,          64'h0,  64'h0,  64'h0,  4'b1111, 5,  1'b0};
    tbl[9] = '{1'b0, 8'd100, 8'd3, 64'h0,          64'h0,  64'h0,  64'h0,  4'b1111, 6,  1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {58'd0, cmd_ready, busy, done, wr_ready, rd_valid, ram_cen}, 64'b100000);
    chk("rst_ram_pins", {55'd0, ram_wen, ram_addr}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_din", ram_din, 64'd0);
    reset = 1'b0;

    for (int t = 0; t < 9; t++) run_burst(tbl[t]);

    // Abort a 4-word write during its second beat.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'd100; cmd_len = 8'd3;
    @(negedge clk);
    chk("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 64'hd0d0_0000_0000_00d0;
    @(negedge clk);
    chk("abort_beat0", {54'd0, ram_cen, ram_wen, ram_addr}, {54'd0, 2'b11, 8'd100});
    @(posedge clk); #1;
    wr_data = 64'hd1d1_0000_0000_00d1;
    #2;
    reset = 1'b1;
    #1;
    chk("abort_ctrl", {58'd0, cmd_ready, busy, done, wr_ready, rd_valid, ram_cen}, 64'b100000);
    chk("abort_ram_pins", {55'd0, ram_wen, ram_addr}, 64'd0);
    chk("abort_din", ram_din, 64'd0);
    chk("abort_rd_data", rd_data, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; wr_valid = 1'b0;
    exp_mem[100] = 64'hd0d0_0000_0000_00d0;

    run_burst(tbl[9]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst access controller sitting directly upstream of the 256×64 single-port `ram`, driving its `cen`/`wen`/`addr`/`din` pins and consuming `dout`. It accepts one command (read or write, start address, length), then streams write data in or read data out over valid/ready handshakes at up to one word per cycle. It is the only master of the RAM port.

## Interface
- ADDR_W, 8, RAM address width (256 words)
- DATA_W, 64, RAM word width
- LEN_W, 8, burst length field; words per burst = cmd_len+1 (1..256)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start word address
- cmd_len  in  LEN_W  word count minus one
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted
- wr_data  in  DATA_W  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  downstream accepts read word
- rd_data  out  DATA_W  read word (registered)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion
- ram_cen, ram_wen  out  1 each  to RAM cen/wen
- ram_addr  out  ADDR_W  to RAM addr
- ram_din  out  DATA_W  to RAM din
- ram_dout  in  DATA_W  from RAM dout

## Operation
- RAM contract: write at rising edge when cen=1, wen=1; dout combinational, valid in the same cycle when cen=1, wen=0, else 0.
- States: IDLE, WRITE, READ, RDRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch cur_addr=cmd_addr, cnt=cmd_len, dir. Go to WRITE or READ.
- WRITE: wr_ready=1. When wr_valid: ram_cen=1, ram_wen=1, ram_din=wr_data, ram_addr=cur_addr. On each beat cur_addr+1 (mod 256) and cnt−1. When the beat occurs with cnt==0, go to DONE.
- READ: issue a read (ram_cen=1, ram_wen=0) when the output register is empty or being drained this cycle (rd_valid&rd_ready). Capture ram_dout into rd_data and set rd_valid. Advance cur_addr/cnt as in WRITE. When the issue occurs with cnt==0, go to RDRAIN.
- RDRAIN: no RAM access. When rd_valid&rd_ready, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- rd_valid clears on handshake unless refilled in the same cycle.
- Address wraps 255→0. There is no error for bursts crossing the end of memory.
- ram_cen=0 whenever no beat/issue occurs. ram_addr=cur_addr always. ram_din=0 outside WRITE beats.
- cmd_valid outside IDLE is ignored, and the command is not queued.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0, ram_cen=0, ram_wen=0, ram_addr=0, ram_din=0, cur_addr=0, cnt=0.
- Command accepted in cycle N. Busy and first possible beat in cycle N+1.
- Write: data is written at the edge ending the beat cycle. Full-rate burst of L+1 words gives done in cycle N+L+2.
- Read: issued in cycle K, rd_valid/rd_data in K+1. With rd_ready held high, throughput is 1 word/cycle. Done occurs one cycle after the last handshake.
- rd_data and rd_valid are stable while rd_valid=1 and rd_ready=0.
- Reset asserted mid-burst aborts immediately to reset values. RAM contents are not touched. A partial write burst leaves earlier beats written.

## Structure
- Package ram_ctrl_pkg: state enum, ADDR_W/DATA_W/LEN_W defaults, direction constants.
- Single module with no sub-modules. The bench instantiates `ram` behind it.

## Test plan
- Write burst addr 10, len 2, data 64'h12aabbcc, 64'h34, 64'h56 with wr_valid held high -> three writes in consecutive cycles to 10,11,12; done in cycle N+4.
- Read burst addr 10, len 2, rd_ready=1 -> rd_data 64'h12aabbcc, 64'h34, 64'h56 in cycles N+2..N+4; done pulse follows.
- Read with rd_ready toggling 1,0,0,1 -> no word lost or duplicated; ram_cen low during stalls; rd_data held steady.
- Write addr 255, len 1, data A,B -> mem[255]=A, mem[0]=B; readback confirms the wrap.
- cmd_valid pulsed during an active burst -> ignored; cmd_ready=0; burst completes unchanged.
- Reset asserted in cycle 2 of a 4-word write -> outputs return to reset values asynchronously; first beat is retained in RAM, later beats are absent.
